// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: elastic IF/ID stage with a 2-entry skid buffer, flush masking and a saturating flush counter.
// in_ready is a register, so decode stalls never reach fetch combinationally.
module if_id_skid_stage #(
   parameter int                   WORD_SIZE = 16,
   parameter int                   PC_WIDTH  = 16,
   parameter logic [WORD_SIZE-1:0] NOP_VALUE = '0,
   parameter int                   CNT_WIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PC_WIDTH-1:0]  in_pc,
   input  logic [WORD_SIZE-1:0] in_instr,
   input  logic                 Flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PC_WIDTH-1:0]  out_pc,
   output logic [WORD_SIZE-1:0] out_instr,
   output logic [1:0]           occupancy,
   output logic [CNT_WIDTH-1:0] flush_cnt
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   state_t               state;
   logic                 valid_q;
   logic                 ready_q;
   logic [PC_WIDTH-1:0]  main_pc;
   logic [PC_WIDTH-1:0]  skid_pc;
   logic [WORD_SIZE-1:0] main_instr;
   logic [WORD_SIZE-1:0] skid_instr;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 in_fire;
   logic                 out_fire;
   assign in_ready  = ready_q;
   assign in_fire   = in_valid & ready_q;
   assign out_valid = valid_q & ~Flush;
   assign out_fire  = out_valid & out_ready;
   assign out_pc    = main_pc;
   assign out_instr = out_valid ? main_instr : NOP_VALUE;
   assign occupancy = state;
   assign flush_cnt = cnt;
   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         state      <= EMPTY;
         valid_q    <= 1'b0;
         ready_q    <= 1'b1;
         main_pc    <= '0;
         main_instr <= NOP_VALUE;
         skid_pc    <= '0;
         skid_instr <= '0;
         cnt        <= '0;
      end else if (Flush) begin
         state      <= EMPTY;
         valid_q    <= 1'b0;
         ready_q    <= 1'b1;
         skid_pc    <= '0;
         skid_instr <= '0;
         // only flushes that actually threw work away are counted
         if ((state != EMPTY || in_fire) && !(&cnt))
            cnt <= cnt + 1'b1;
      end else begin
         case (state)
            EMPTY:
               if (in_fire) begin
                  state      <= ONE;
                  valid_q    <= 1'b1;
                  main_pc    <= in_pc;
                  main_instr <= in_instr;
               end
            ONE:
               if (in_fire && out_fire) begin
                  main_pc    <= in_pc;
                  main_instr <= in_instr;
               end else if (out_fire) begin
                  state   <= EMPTY;
                  valid_q <= 1'b0;
               end else if (in_fire) begin
                  state      <= FULL;
                  skid_pc    <= in_pc;
                  skid_instr <= in_instr;
                  ready_q    <= 1'b0;
               end
            FULL:
               if (out_fire) begin
                  state      <= ONE;
                  main_pc    <= skid_pc;
                  main_instr <= skid_instr;
                  ready_q    <= 1'b1;
               end
            default: begin
               state   <= EMPTY;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb_if_id_skid_stage: directed vector table plus randomized traffic against a queue-based reference model.
module tb_if_id_skid_stage;
   localparam logic [15:0] NOP = 16'hDEAD;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_pc = '0;
   logic [15:0] in_instr = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_pc;
   logic [15:0] out_instr;
   logic [1:0]  occupancy;
   logic [7:0]  flush_cnt;
   int vectors = 0;
   int miscompares = 0;

   if_id_skid_stage #(.WORD_SIZE(16), .PC_WIDTH(16), .NOP_VALUE(NOP), .CNT_WIDTH(8)) dut (
      .Clk(clk), .Reset_N(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .Flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .occupancy(occupancy), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, iv;
      logic [15:0] pc, ins;
      logic        fl, ordy, e_ov;
      logic [15:0] e_pc, e_ins;
      logic        e_rdy;
      logic [1:0]  e_occ;
      logic [7:0]  e_cnt;
   } vec_t;
   typedef struct { logic [15:0] pc, ins; } ent_t;

   vec_t tbl[$];
   ent_t q[$];
   logic [15:0] m_last;
   int  m_cnt;
   bit  m_init = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [15:0] pc, ins, input logic fl, ordy, e_ov,
                      input logic [15:0] e_pc, e_ins, input logic e_rdy, input logic [1:0] e_occ,
                      input logic [7:0] e_cnt);
      tbl.push_back('{1'b1, iv, pc, ins, fl, ordy, e_ov, e_pc, e_ins, e_rdy, e_occ, e_cnt});
   endtask

   task automatic run(input vec_t v, input bit tchk);
      logic m_ov, m_rdy, fin, fout;
      rst_n = v.rst_n; in_valid = v.iv; in_pc = v.pc; in_instr = v.ins;
      flush = v.fl; out_ready = v.ordy;
      @(negedge clk);
      if (tchk) begin
         chk("tbl_out_valid", {31'b0, out_valid}, {31'b0, v.e_ov});
         chk("tbl_out_pc", {16'b0, out_pc}, {16'b0, v.e_pc});
         chk("tbl_out_instr", {16'b0, out_instr}, {16'b0, v.e_ins});
         chk("tbl_in_ready", {31'b0, in_ready}, {31'b0, v.e_rdy});
         chk("tbl_occupancy", {30'b0, occupancy}, {30'b0, v.e_occ});
         chk("tbl_flush_cnt", {24'b0, flush_cnt}, {24'b0, v.e_cnt});
      end
      m_ov  = q.size() > 0 && !v.fl;
      m_rdy = q.size() < 2;
      if (m_init) begin
         chk("mdl_out_valid", {31'b0, out_valid}, {31'b0, m_ov});
         chk("mdl_out_pc", {16'b0, out_pc}, {16'b0, q.size() > 0 ? q[0].pc : m_last});
         chk("mdl_out_instr", {16'b0, out_instr}, {16'b0, m_ov ? q[0].ins : NOP});
         chk("mdl_in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
         chk("mdl_occupancy", {30'b0, occupancy}, q.size());
         chk("mdl_flush_cnt", {24'b0, flush_cnt}, m_cnt);
      end
      fin  = v.iv && m_rdy;
      fout = m_ov && v.ordy;
      @(posedge clk);
      if (!v.rst_n) begin
         q.delete(); m_last = '0; m_cnt = 0; m_init = 1'b1;
      end else if (v.fl) begin
         if (q.size() > 0 || fin) m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
         q.delete();
      end else begin
         if (fout) void'(q.pop_front());
         if (fin) q.push_back('{v.pc, v.ins});
      end
      if (q.size() > 0) m_last = q[0].pc;
      #1;
   endtask

   task automatic drive(input logic r, iv, input logic [15:0] pc, ins, input logic fl, ordy);
      vec_t v;
      v = '{r, iv, pc, ins, fl, ordy, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 8'd0};
      run(v, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++)
         add(1'b1, 16'(i), 16'(16'h1000 + i), 1'b0, 1'b1, i > 0, i > 0 ? 16'(i - 1) : 16'h0,
             i > 0 ? 16'(16'h1000 + i - 1) : NOP, 1'b1, i > 0 ? 2'd1 : 2'd0, 8'd0);
      add(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h7, 16'h1007, 1'b1, 2'd1, 8'd0);
      add(1'b1, 16'h10, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h7, NOP, 1'b1, 2'd0, 8'd0);
      add(1'b1, 16'h11, 16'h0011, 1'b0, 1'b0, 1'b1, 16'h10, 16'h0010, 1'b1, 2'd1, 8'd0);
      for (int i = 0; i < 3; i++)
         add(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h10, 16'h0010, 1'b0, 2'd2, 8'd0);
      add(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h10, 16'h0010, 1'b0, 2'd2, 8'd0);
      add(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h11, 16'h0011, 1'b1, 2'd1, 8'd0);
      add(1'b1, 16'h20, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h11, NOP, 1'b1, 2'd0, 8'd0);
      add(1'b1, 16'h21, 16'h0021, 1'b0, 1'b0, 1'b1, 16'h20, 16'h0020, 1'b1, 2'd1, 8'd0);
      add(1'b1, 16'h22, 16'h2222, 1'b1, 1'b1, 1'b0, 16'h20, NOP, 1'b0, 2'd2, 8'd0);
      add(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h20, NOP, 1'b1, 2'd0, 8'd1);
      add(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h20, NOP, 1'b1, 2'd0, 8'd1);
      add(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h20, NOP, 1'b1, 2'd0, 8'd1);

      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      foreach (tbl[i]) run(tbl[i], 1'b1);

      for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 16'(i), 16'h3333, 1'b1, 1'b1);
      chk("flush_cnt_saturated", {24'b0, flush_cnt}, 32'd255);
      drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      chk("flush_cnt_held_sat", {24'b0, flush_cnt}, 32'd255);

      drive(1'b1, 1'b1, 16'h40, 16'h4040, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 16'h41, 16'h4141, 1'b0, 1'b0);
      chk("full_before_reset", {30'b0, occupancy}, 32'd2);
      drive(1'b0, 1'b1, 16'h42, 16'h4242, 1'b1, 1'b0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_pc", {16'b0, out_pc}, 32'd0);
      chk("rst_out_instr", {16'b0, out_instr}, {16'b0, NOP});
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_occupancy", {30'b0, occupancy}, 32'd0);
      chk("rst_flush_cnt", {24'b0, flush_cnt}, 32'd0);

      for (int i = 0; i < 2000; i++)
         drive(1'b1, ($urandom % 4) != 0, 16'($urandom), 16'($urandom),
               ($urandom % 64) == 0, ($urandom % 3) != 0);
      drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
